// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths.
// The state encoding is common to both directions. UART_BIT is the
// data-bit state: BIT_RX in the receiver and BIT_TX in the transmitter.
// UART_BREAK is only entered by the receiver.
package uart_pkg;

   localparam int UART_DATAWIDTH = 8;

   typedef enum logic [2:0] {
      UART_IDLE  = 3'd0,
      UART_START = 3'd1,
      UART_BIT   = 3'd2,
      UART_STOP  = 3'd3,
      UART_BREAK = 3'd4
   } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
// Both flops reset to RESET_VAL so that an idle-high line reads as idle
// immediately after reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Each flop simply takes the value of the stage before it.
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   // Register both stages, with a synchronous reset to the idle level.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver. It takes a start bit, DATAWIDTH data bits sent LSB first,
// and one stop bit. The received word is held on DATA with a DATARDY/READ
// handshake. FRAMEERR and OVERRUN are single-cycle pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATAWIDTH    = UART_DATAWIDTH,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RX,
   output logic [DATAWIDTH-1:0] DATA,
   output logic                 DATARDY,
   input  logic                 READ,
   output logic                 FRAMEERR,
   output logic                 OVERRUN
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

   // The start bit is sampled half a bit in, so that every later sample
   // lands in the middle of its bit.
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATAWIDTH - 1);

   logic                 rx_s;

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATAWIDTH-1:0] shreg_q, shreg_d;
   logic [DATAWIDTH-1:0] data_q, data_d;
   logic                 data_rdy_q, data_rdy_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk      (CLK),
      .rst      (RST),
      .async_in (RX),
      .sync_out (rx_s)
   );

   // This block computes the next frame state, the bit timing and the
   // output flags. A completed frame is delivered in the same cycle that
   // the stop bit is sampled. A READ in that same cycle consumes the old
   // word, so it does not count as an overrun.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      data_rdy_d  = data_rdy_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      if (data_rdy_q && READ) begin
         data_rdy_d = 1'b0;
      end

      case (state_q)
         UART_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = UART_START;
            end
         end

         UART_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = UART_BIT;
                  bit_idx_d = '0;
               end else begin
                  state_d = UART_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         UART_BIT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d            = '0;
               shreg_d[bit_idx_q] = rx_s;
               if (bit_idx_q == IDX_LAST) begin
                  state_d   = UART_STOP;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         UART_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d    = UART_IDLE;
                  data_d     = shreg_q;
                  data_rdy_d = 1'b1;
                  overrun_d  = data_rdy_q && !READ;
               end else begin
                  state_d     = UART_BREAK;
                  frame_err_d = 1'b1;
                  shreg_d     = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         UART_BREAK: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = UART_IDLE;
            end
         end

         default: begin
            state_d = UART_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers. Reset abandons any frame that is in
   // progress and raises no flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= UART_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         data_rdy_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         data_rdy_q  <= data_rdy_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign DATA     = data_q;
   assign DATARDY  = data_rdy_q;
   assign FRAMEERR = frame_err_q;
   assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit with 8 data bits.
// Frames are driven on falling clock edges, and outputs are sampled on
// falling edges as well.
module tb_uart_rx;

   localparam int DW  = 8;
   localparam int CPB = 16;

   // A frame whose start bit is driven at n=0 is delivered with DATARDY
   // visible at falling edge 155. The count is 2 synchronizer cycles,
   // plus 1 cycle for IDLE to see the low level, plus 8 + 9*16 cycles
   // up to the stop sample.
   localparam int DELIVER_AT = 155;

   logic          CLK = 1'b0;
   logic          RST;
   logic          RX;
   logic          READ;
   logic [DW-1:0] DATA;
   logic          DATARDY;
   logic          FRAMEERR;
   logic          OVERRUN;

   int total = 0;
   int bad   = 0;

   int   rdyAt, feAt, ovAt, feCnt, ovCnt;
   logic rdyPrev;

   uart_rx #(
      .DATAWIDTH    (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .RX       (RX),
      .DATA     (DATA),
      .DATARDY  (DATARDY),
      .READ     (READ),
      .FRAMEERR (FRAMEERR),
      .OVERRUN  (OVERRUN)
   );

   // Free-running clock with a 10 ns period.
   always #5 CLK = ~CLK;

   // Record one comparison, and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Clear the event record before the next observation window.
   task automatic clearWatch();
      rdyAt   = -1;
      feAt    = -1;
      ovAt    = -1;
      feCnt   = 0;
      ovCnt   = 0;
      rdyPrev = DATARDY;
   endtask

   // Record the first DATARDY rise and every flag pulse, with the cycle index.
   task automatic sampleOutputs(input int n);
      if (DATARDY && !rdyPrev && rdyAt < 0) rdyAt = n;
      rdyPrev = DATARDY;
      if (FRAMEERR) begin
         feCnt++;
         if (feAt < 0) feAt = n;
      end
      if (OVERRUN) begin
         ovCnt++;
         if (ovAt < 0) ovAt = n;
      end
   endtask

   // Wait a number of cycles while continuing to record events.
   task automatic idleCycles(input int cycles);
      for (int i = 1; i <= cycles; i++) begin
         @(negedge CLK);
         sampleOutputs(i);
      end
   endtask

   // Drive one full frame, starting at the current falling edge.
   // RX is left at the stop-bit level when the task returns. If readAt
   // is nonzero, READ is held high across the rising edge that precedes
   // falling edge readAt.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int readAt);
      logic [9:0] frame;
      frame = {stopBit, data, 1'b0};
      clearWatch();
      RX = frame[0];
      for (int n = 1; n <= 10 * CPB; n++) begin
         @(negedge CLK);
         sampleOutputs(n);
         if (readAt != 0 && n == readAt - 1) READ = 1'b1;
         if (readAt != 0 && n == readAt) READ = 1'b0;
         if ((n % CPB) == 0 && n < 10 * CPB) RX = frame[n / CPB];
      end
   endtask

   // Pulse READ for one cycle, then check that the word is released but still held.
   task automatic doRead(input string tag, input logic [7:0] expData);
      READ = 1'b1;
      @(negedge CLK);
      READ = 1'b0;
      checkOutput({tag, "_rdy_clr"}, 32'(DATARDY), 32'd0);
      checkOutput({tag, "_data_hold"}, 32'(DATA), 32'(expData));
   endtask

   // Main directed sequence.
   initial begin
      RST  = 1'b1;
      RX   = 1'b1;
      READ = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("rst_data", 32'(DATA), 32'd0);
      checkOutput("rst_rdy",  32'(DATARDY), 32'd0);
      checkOutput("rst_fe",   32'(FRAMEERR), 32'd0);
      checkOutput("rst_ov",   32'(OVERRUN), 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      $display("[TB] single frame 0xA5");
      applyStimulus(8'hA5, 1'b1, 0);
      checkOutput("a5_rdy_at", 32'(rdyAt), 32'(DELIVER_AT));
      checkOutput("a5_data",   32'(DATA), 32'hA5);
      checkOutput("a5_flags",  32'(feCnt + ovCnt), 32'd0);
      idleCycles(20);
      checkOutput("a5_rdy_hold",  32'(DATARDY), 32'd1);
      checkOutput("a5_data_hold", 32'(DATA), 32'hA5);
      doRead("a5", 8'hA5);

      $display("[TB] glitch then 0x3C");
      clearWatch();
      RX = 1'b0;
      idleCycles(4);
      RX = 1'b1;
      idleCycles(40);
      checkOutput("gl_rdy",   32'(rdyAt), 32'hFFFF_FFFF);
      checkOutput("gl_flags", 32'(feCnt + ovCnt), 32'd0);
      applyStimulus(8'h3C, 1'b1, 0);
      checkOutput("gl_3c_at",   32'(rdyAt), 32'(DELIVER_AT));
      checkOutput("gl_3c_data", 32'(DATA), 32'h3C);
      doRead("gl_3c", 8'h3C);

      $display("[TB] framing error 0x55 then 0x0F");
      applyStimulus(8'h55, 1'b0, 0);
      checkOutput("fe_at", 32'(feAt), 32'(DELIVER_AT));
      idleCycles(40);
      RX = 1'b1;
      idleCycles(200);
      checkOutput("fe_cnt", 32'(feCnt), 32'd1);
      checkOutput("fe_rdy", 32'(rdyAt), 32'hFFFF_FFFF);
      checkOutput("fe_ov",  32'(ovCnt), 32'd0);
      applyStimulus(8'h0F, 1'b1, 0);
      checkOutput("fe_0f_at",   32'(rdyAt), 32'(DELIVER_AT));
      checkOutput("fe_0f_data", 32'(DATA), 32'h0F);
      checkOutput("fe_0f_fe",   32'(feCnt), 32'd0);
      doRead("fe_0f", 8'h0F);

      $display("[TB] overrun 0x11 then 0x22");
      applyStimulus(8'h11, 1'b1, 0);
      checkOutput("ov_first_at", 32'(rdyAt), 32'(DELIVER_AT));
      applyStimulus(8'h22, 1'b1, 0);
      checkOutput("ov_at",   32'(ovAt), 32'(DELIVER_AT));
      checkOutput("ov_cnt",  32'(ovCnt), 32'd1);
      checkOutput("ov_data", 32'(DATA), 32'h22);
      checkOutput("ov_rdy",  32'(DATARDY), 32'd1);
      checkOutput("ov_fe",   32'(feCnt), 32'd0);
      doRead("ov", 8'h22);

      $display("[TB] delivery coinciding with read");
      applyStimulus(8'h11, 1'b1, 0);
      checkOutput("sim_first_data", 32'(DATA), 32'h11);
      applyStimulus(8'h22, 1'b1, DELIVER_AT);
      checkOutput("sim_ov",   32'(ovCnt), 32'd0);
      checkOutput("sim_data", 32'(DATA), 32'h22);
      checkOutput("sim_rdy",  32'(DATARDY), 32'd1);

      $display("[TB] reset during data bit 3 of 0xFF");
      RX = 1'b0;
      idleCycles(CPB);
      RX = 1'b1;
      idleCycles(3 * CPB + CPB / 2);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checkOutput("rs_data", 32'(DATA), 32'd0);
      checkOutput("rs_rdy",  32'(DATARDY), 32'd0);
      checkOutput("rs_fe",   32'(FRAMEERR), 32'd0);
      checkOutput("rs_ov",   32'(OVERRUN), 32'd0);
      clearWatch();
      idleCycles(200);
      checkOutput("rs_flags", 32'(feCnt + ovCnt), 32'd0);
      checkOutput("rs_quiet", 32'(rdyAt), 32'hFFFF_FFFF);
      applyStimulus(8'h81, 1'b1, 0);
      checkOutput("rs_81_at",   32'(rdyAt), 32'(DELIVER_AT));
      checkOutput("rs_81_data", 32'(DATA), 32'h81);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
